// File: rtl/wb_arbiter_int_pkg.sv
// rtl/wb_arbiter_int_pkg.sv - shared sizes, entry type and helpers for the integer writeback arbiter
package wb_arbiter_int_pkg;

  localparam int PRF_INT_WAYS       = 2;
  localparam int PRF_INT_INDEX_SIZE = 6;
  localparam int ROB_INDEX_SIZE     = 5;

  // One buffered FU result as held in a per-FU queue.
  typedef struct packed {
    logic                          rd_wen;
    logic [PRF_INT_INDEX_SIZE-1:0] prd;
    logic [31:0]                   data;
    logic [ROB_INDEX_SIZE-1:0]     rob_idx;
  } wb_entry_t;

  // Single-step modulo wrap; callers only ever pass v < 2*n.
  function automatic int rr_wrap(input int v, input int n);
    return (v >= n) ? (v - n) : v;
  endfunction

endpackage

// File: rtl/wb_arbiter_int_if.sv
// rtl/wb_arbiter_int_if.sv - FU result inputs and PRF/ROB writeback outputs of the arbiter
interface wb_arbiter_int_if
  import wb_arbiter_int_pkg::*;
#(
  parameter int FU_NUM    = 4,
  parameter int WAYS      = PRF_INT_WAYS,
  parameter int PRF_IDX_W = PRF_INT_INDEX_SIZE,
  parameter int ROB_IDX_W = ROB_INDEX_SIZE
) ();

  logic [FU_NUM-1:0]                fu_valid;
  logic [FU_NUM-1:0]                fu_ready;
  logic [FU_NUM-1:0]                fu_rd_wen;
  logic [FU_NUM-1:0][PRF_IDX_W-1:0] fu_prd;
  logic [FU_NUM-1:0][31:0]          fu_data;
  logic [FU_NUM-1:0][ROB_IDX_W-1:0] fu_rob_idx;

  logic [WAYS-1:0]                  rd_en;
  logic [WAYS-1:0][PRF_IDX_W-1:0]   rd_index;
  logic [WAYS-1:0][31:0]            rd_data;
  logic [WAYS-1:0]                  complete_valid;
  logic [WAYS-1:0][ROB_IDX_W-1:0]   complete_rob_idx;

  // FU / PRF side
  modport master (
    output fu_valid, fu_rd_wen, fu_prd, fu_data, fu_rob_idx,
    input  fu_ready, rd_en, rd_index, rd_data, complete_valid, complete_rob_idx
  );

  // Arbiter side
  modport slave (
    input  fu_valid, fu_rd_wen, fu_prd, fu_data, fu_rob_idx,
    output fu_ready, rd_en, rd_index, rd_data, complete_valid, complete_rob_idx
  );

endinterface

// File: rtl/wb_arbiter_int_fifo.sv
// rtl/wb_arbiter_int_fifo.sv - per-FU synchronous result queue (power-of-two depth)
module wb_arbiter_int_fifo
  import wb_arbiter_int_pkg::*;
#(
  parameter type entry_t = wb_entry_t,
  parameter int  DEPTH   = 2
) (
  input  logic   clock_i,
  input  logic   reset_i,
  input  logic   flush_i,
  input  logic   push_i,
  input  logic   pop_i,
  input  entry_t data_i,
  output logic   full_o,
  output logic   empty_o,
  output entry_t head_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Next pointers/count; flush discards everything, pointers wrap naturally
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents of empty slots are never observed
  always_ff @(posedge clock_i) begin
    if (do_push && !flush_i && !reset_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/wb_arbiter_int.sv
// rtl/wb_arbiter_int.sv - integer writeback: per-FU queues, round-robin multi-way grant, registered PRF/ROB outputs
module wb_arbiter_int
  import wb_arbiter_int_pkg::*;
#(
  parameter int FU_NUM      = 4,
  parameter int WAYS        = PRF_INT_WAYS,
  parameter int PRF_IDX_W   = PRF_INT_INDEX_SIZE,
  parameter int ROB_IDX_W   = ROB_INDEX_SIZE,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               flush_i,
  wb_arbiter_int_if.slave    bus_io
);

  localparam int PW = (FU_NUM > 1) ? $clog2(FU_NUM) : 1;
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef struct packed {
    logic                 rd_wen;
    logic [PRF_IDX_W-1:0] prd;
    logic [31:0]          data;
    logic [ROB_IDX_W-1:0] rob_idx;
  } entry_t;

  entry_t            in_entry [FU_NUM];
  entry_t            heads    [FU_NUM];
  entry_t            way_head [WAYS];
  logic [FU_NUM-1:0] full, empty, push, pop;
  logic [WAYS-1:0]   way_vld;
  logic [PW-1:0]     way_src  [WAYS];
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;

  logic [WAYS-1:0]                rd_en_q, rd_en_d;
  logic [WAYS-1:0][PRF_IDX_W-1:0] rd_index_q, rd_index_d;
  logic [WAYS-1:0][31:0]          rd_data_q, rd_data_d;
  logic [WAYS-1:0]                cv_q, cv_d;
  logic [WAYS-1:0][ROB_IDX_W-1:0] crob_q, crob_d;

  // Ready depends only on registered occupancy, never on this cycle's pop
  assign bus_io.fu_ready = ~full;

  for (genvar g = 0; g < FU_NUM; g++) begin : g_fu
    assign in_entry[g] = '{rd_wen:  bus_io.fu_rd_wen[g],
                           prd:     bus_io.fu_prd[g],
                           data:    bus_io.fu_data[g],
                           rob_idx: bus_io.fu_rob_idx[g]};
    assign push[g] = bus_io.fu_valid[g] & ~full[g] & ~flush_i;

    wb_arbiter_int_fifo #(.entry_t(entry_t), .DEPTH(QUEUE_DEPTH)) u_fifo (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .flush_i (flush_i),
      .push_i  (push[g]),
      .pop_i   (pop[g]),
      .data_i  (in_entry[g]),
      .full_o  (full[g]),
      .empty_o (empty[g]),
      .head_o  (heads[g])
    );
  end

  // Round-robin scan from rr_ptr: first WAYS non-empty heads go to ways 0.. in scan order
  always_comb begin
    int n;
    int f;
    way_vld  = '0;
    pop      = '0;
    rr_ptr_d = rr_ptr_q;
    for (int k = 0; k < WAYS; k++) way_src[k] = '0;
    n = 0;
    for (int j = 0; j < FU_NUM; j++) begin
      f = rr_wrap(int'(rr_ptr_q) + j, FU_NUM);
      if (!flush_i && !empty[PW'(f)] && n < WAYS) begin
        pop[PW'(f)]        = 1'b1;
        way_vld[WW'(n)]    = 1'b1;
        way_src[WW'(n)]    = PW'(f);
        rr_ptr_d           = PW'(rr_wrap(f + 1, FU_NUM));
        n                  = n + 1;
      end
    end
  end

  // Head selected for each way
  always_comb begin
    for (int k = 0; k < WAYS; k++) way_head[k] = heads[way_src[k]];
  end

  // Output next-state; idle ways carry all-zero fields
  always_comb begin
    for (int k = 0; k < WAYS; k++) begin
      rd_en_d[k]    = way_vld[k] & way_head[k].rd_wen;
      rd_index_d[k] = way_vld[k] ? way_head[k].prd     : '0;
      rd_data_d[k]  = way_vld[k] ? way_head[k].data    : '0;
      cv_d[k]       = way_vld[k];
      crob_d[k]     = way_vld[k] ? way_head[k].rob_idx : '0;
    end
  end

  // Flop-driven PRF/ROB outputs and round-robin pointer
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rd_en_q    <= '0;
      rd_index_q <= '0;
      rd_data_q  <= '0;
      cv_q       <= '0;
      crob_q     <= '0;
      rr_ptr_q   <= '0;
    end else begin
      rd_en_q    <= rd_en_d;
      rd_index_q <= rd_index_d;
      rd_data_q  <= rd_data_d;
      cv_q       <= cv_d;
      crob_q     <= crob_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign bus_io.rd_en            = rd_en_q;
  assign bus_io.rd_index         = rd_index_q;
  assign bus_io.rd_data          = rd_data_q;
  assign bus_io.complete_valid   = cv_q;
  assign bus_io.complete_rob_idx = crob_q;

endmodule

// File: tb/tb_wb_arbiter_int.sv
// tb/tb_wb_arbiter_int.sv - directed and random checks of wb_arbiter_int against a queue model
module tb_wb_arbiter_int;
  import wb_arbiter_int_pkg::*;

  localparam int FU_NUM = 4;
  localparam int WAYS   = PRF_INT_WAYS;
  localparam int PW     = PRF_INT_INDEX_SIZE;
  localparam int RW     = ROB_INDEX_SIZE;
  localparam int DEPTH  = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  always #5 clock = ~clock;

  wb_arbiter_int_if #(.FU_NUM(FU_NUM), .WAYS(WAYS), .PRF_IDX_W(PW), .ROB_IDX_W(RW)) bus ();

  wb_arbiter_int #(.FU_NUM(FU_NUM), .WAYS(WAYS), .PRF_IDX_W(PW), .ROB_IDX_W(RW),
                   .QUEUE_DEPTH(DEPTH)) dut (
    .clock_i (clock),
    .reset_i (reset),
    .flush_i (flush),
    .bus_io  (bus)
  );

  typedef struct {
    logic          wen;
    logic [PW-1:0] prd;
    logic [31:0]   data;
    logic [RW-1:0] rob;
  } ent_t;

  int   checks = 0;
  int   errors = 0;
  ent_t mq [FU_NUM][$];
  int   rr = 0;
  bit   acc [FU_NUM];
  int   fu0_data, next_exp;
  bit   saw_full;

  logic [WAYS-1:0]          e_en, e_cv;
  logic [WAYS-1:0][PW-1:0]  e_idx;
  logic [WAYS-1:0][31:0]    e_data;
  logic [WAYS-1:0][RW-1:0]  e_rob;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.fu_valid   = '0;
    bus.fu_rd_wen  = '0;
    bus.fu_prd     = '0;
    bus.fu_data    = '0;
    bus.fu_rob_idx = '0;
  endtask

  task automatic set_fu(input int i, input logic wen, input logic [PW-1:0] prd,
                        input logic [31:0] data, input logic [RW-1:0] rob);
    bus.fu_valid[i]   = 1'b1;
    bus.fu_rd_wen[i]  = wen;
    bus.fu_prd[i]     = prd;
    bus.fu_data[i]    = data;
    bus.fu_rob_idx[i] = rob;
  endtask

  // One clock: model decides acceptances and grants from pre-edge state, then outputs are compared.
  task automatic cycle();
    logic [FU_NUM-1:0] rdy;
    ent_t e;
    int g, last, f;
    for (int i = 0; i < FU_NUM; i++) rdy[i] = (mq[i].size() != DEPTH);
    if (!reset) check("fu_ready", 64'(bus.fu_ready), 64'(rdy));
    e_en = '0; e_cv = '0; e_idx = '0; e_data = '0; e_rob = '0;
    for (int i = 0; i < FU_NUM; i++) acc[i] = 1'b0;
    if (reset) begin
      for (int i = 0; i < FU_NUM; i++) mq[i].delete();
      rr = 0;
    end else if (flush) begin
      for (int i = 0; i < FU_NUM; i++) mq[i].delete();
    end else begin
      g = 0;
      last = -1;
      for (int j = 0; j < FU_NUM; j++) begin
        f = (rr + j) % FU_NUM;
        if (g < WAYS && mq[f].size() > 0) begin
          e = mq[f].pop_front();
          e_en[g]   = e.wen;
          e_cv[g]   = 1'b1;
          e_idx[g]  = e.prd;
          e_data[g] = e.data;
          e_rob[g]  = e.rob;
          g++;
          last = f;
        end
      end
      if (last >= 0) rr = (last + 1) % FU_NUM;
      for (int i = 0; i < FU_NUM; i++) begin
        if (bus.fu_valid[i] && rdy[i]) begin
          e.wen  = bus.fu_rd_wen[i];
          e.prd  = bus.fu_prd[i];
          e.data = bus.fu_data[i];
          e.rob  = bus.fu_rob_idx[i];
          mq[i].push_back(e);
          acc[i] = 1'b1;
        end
      end
    end
    @(posedge clock);
    #1;
    check("rd_en",            64'(bus.rd_en),            64'(e_en));
    check("rd_index",         64'(bus.rd_index),         64'(e_idx));
    check("rd_data",          64'(bus.rd_data),          64'(e_data));
    check("complete_valid",   64'(bus.complete_valid),   64'(e_cv));
    check("complete_rob_idx", 64'(bus.complete_rob_idx), 64'(e_rob));
  endtask

  task automatic scan_fu0();
    for (int k = 0; k < WAYS; k++) begin
      if (bus.complete_valid[k] && bus.complete_rob_idx[k] == '0) begin
        check("fu0_order", 64'(bus.rd_data[k]), 64'(next_exp));
        next_exp++;
      end
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    flush = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
    check("reset_rd_en",    64'(bus.rd_en),          64'd0);
    check("reset_cv",       64'(bus.complete_valid), 64'd0);
    check("reset_rd_data",  64'(bus.rd_data),        64'd0);
    check("reset_fu_ready", 64'(bus.fu_ready),       64'hf);

    // Single result from FU1 at cycle 10
    for (int c = 2; c < 10; c++) cycle();
    set_fu(1, 1'b1, PW'(5), 32'hDEADBEEF, RW'(3));
    cycle();
    idle_inputs();
    check("single_t1_rd_en", 64'(bus.rd_en), 64'd0);
    cycle();
    check("single_rd_en",    64'(bus.rd_en),               64'h1);
    check("single_rd_index", 64'(bus.rd_index[0]),         64'd5);
    check("single_rd_data",  64'(bus.rd_data[0]),          64'hDEADBEEF);
    check("single_cv",       64'(bus.complete_valid),      64'h1);
    check("single_rob",      64'(bus.complete_rob_idx[0]), 64'd3);
    cycle();
    check("single_t3_cv", 64'(bus.complete_valid), 64'd0);

    // Oversubscription from rr_ptr = 0
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int i = 0; i < FU_NUM; i++) set_fu(i, 1'b1, PW'(i + 10), 32'(160 + i), RW'(i));
    cycle();
    idle_inputs();
    cycle();
    check("over1_cv",   64'(bus.complete_valid),      64'h3);
    check("over1_rob0", 64'(bus.complete_rob_idx[0]), 64'd0);
    check("over1_rob1", 64'(bus.complete_rob_idx[1]), 64'd1);
    cycle();
    check("over2_rob0", 64'(bus.complete_rob_idx[0]), 64'd2);
    check("over2_rob1", 64'(bus.complete_rob_idx[1]), 64'd3);
    set_fu(3, 1'b1, PW'(13), 32'h33, RW'(3));
    set_fu(0, 1'b1, PW'(10), 32'h30, RW'(0));
    cycle();
    idle_inputs();
    cycle();
    check("rr_wrap_rob0", 64'(bus.complete_rob_idx[0]), 64'd0);
    check("rr_wrap_rob1", 64'(bus.complete_rob_idx[1]), 64'd3);

    // rd_wen = 0 entry still completes
    set_fu(2, 1'b0, PW'(7), 32'h1234, RW'(9));
    cycle();
    idle_inputs();
    cycle();
    check("nowen_rd_en", 64'(bus.rd_en),               64'd0);
    check("nowen_cv",    64'(bus.complete_valid),      64'h1);
    check("nowen_rob",   64'(bus.complete_rob_idx[0]), 64'd9);
    cycle();

    // Back-pressure on FU0 behind constant traffic from FUs 1..3
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    fu0_data = 1;
    next_exp = 1;
    saw_full = 1'b0;
    for (int c = 0; c < 40; c++) begin
      idle_inputs();
      set_fu(0, 1'b1, PW'(0), 32'(fu0_data), RW'(0));
      for (int i = 1; i < FU_NUM; i++) set_fu(i, 1'b1, PW'(i), 32'(61440 + i), RW'(i));
      if (bus.fu_ready[0] == 1'b0) saw_full = 1'b1;
      cycle();
      if (acc[0]) fu0_data++;
      scan_fu0();
    end
    idle_inputs();
    for (int c = 0; c < 8; c++) begin
      cycle();
      scan_fu0();
    end
    check("fu0_ready_low_seen", 64'(saw_full), 64'd1);
    check("fu0_no_loss",        64'(next_exp), 64'(fu0_data));

    // Flush with three entries buffered
    set_fu(0, 1'b1, PW'(1), 32'h10, RW'(0));
    set_fu(1, 1'b1, PW'(2), 32'h11, RW'(1));
    set_fu(2, 1'b1, PW'(3), 32'h12, RW'(2));
    cycle();
    idle_inputs();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check("flush_rd_en",    64'(bus.rd_en),          64'd0);
    check("flush_cv",       64'(bus.complete_valid), 64'd0);
    check("flush_fu_ready", 64'(bus.fu_ready),       64'hf);
    cycle();
    check("flush_no_stale", 64'(bus.complete_valid), 64'd0);
    set_fu(3, 1'b1, PW'(20), 32'hCAFE, RW'(7));
    cycle();
    idle_inputs();
    check("flush_new_t1", 64'(bus.complete_valid), 64'd0);
    cycle();
    check("flush_new_cv",   64'(bus.complete_valid),      64'h1);
    check("flush_new_rob",  64'(bus.complete_rob_idx[0]), 64'd7);
    check("flush_new_data", 64'(bus.rd_data[0]),          64'hCAFE);
    cycle();

    // Reset mid-stream with full queues
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < FU_NUM; i++) set_fu(i, 1'b1, PW'(i + 1), 32'(4096 + c * 16 + i), RW'(i));
      cycle();
    end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    idle_inputs();
    check("mrst_rd_en",    64'(bus.rd_en),            64'd0);
    check("mrst_cv",       64'(bus.complete_valid),   64'd0);
    check("mrst_rd_index", 64'(bus.rd_index),         64'd0);
    check("mrst_rd_data",  64'(bus.rd_data),          64'd0);
    check("mrst_rob",      64'(bus.complete_rob_idx), 64'd0);
    check("mrst_ready",    64'(bus.fu_ready),         64'hf);
    cycle();
    check("mrst_no_stale1", 64'(bus.rd_en | bus.complete_valid), 64'd0);
    cycle();
    check("mrst_no_stale2", 64'(bus.rd_en | bus.complete_valid), 64'd0);
    set_fu(2, 1'b1, PW'(9), 32'h22, RW'(2));
    set_fu(1, 1'b1, PW'(8), 32'h21, RW'(1));
    cycle();
    idle_inputs();
    cycle();
    check("mrst_rr_rob0", 64'(bus.complete_rob_idx[0]), 64'd1);
    check("mrst_rr_rob1", 64'(bus.complete_rob_idx[1]), 64'd2);

    // Random traffic with occasional flush and reset
    for (int c = 0; c < 500; c++) begin
      idle_inputs();
      for (int i = 0; i < FU_NUM; i++) begin
        if ($urandom_range(0, 99) < 60)
          set_fu(i, 1'($urandom_range(0, 1)), PW'($urandom), $urandom, RW'($urandom));
      end
      flush = ($urandom_range(0, 99) < 3);
      reset = ($urandom_range(0, 199) == 0);
      cycle();
    end
    reset = 1'b0;
    flush = 1'b0;
    idle_inputs();
    for (int c = 0; c < 6; c++) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_arbiter_int.md
Name: wb_arbiter_int

Overview:
- Integer writeback stage: collects results from FU_NUM integer functional units and drives the PRF_INT_WAYS write ports of the integer physical register file (rd_en/rd_index/rd_data).
- Also drives the ROB completion and wakeup broadcast.
- Buffers each FU's results in a small per-FU queue and grants up to PRF_INT_WAYS results per cycle in round-robin order.
- Write-port outputs are registered, so the PRF sees flop-driven write data.

Parameters:
- FU_NUM, 4, number of integer result sources.
- WAYS, `PRF_INT_WAYS, number of PRF write ports / grants per cycle.
- PRF_IDX_W, `PRF_INT_INDEX_SIZE, physical register index width.
- ROB_IDX_W, `ROB_INDEX_SIZE, ROB entry index width.
- QUEUE_DEPTH, 2, entries per FU queue (power of two, ≥2).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  pipeline flush; drop all buffered results.
- fu_valid  in  [FU_NUM]  result valid per FU.
- fu_ready  out  [FU_NUM]  queue can accept (registered-state based).
- fu_rd_wen  in  [FU_NUM]  result writes a register.
- fu_prd  in  [FU_NUM][PRF_IDX_W]  destination physical register.
- fu_data  in  [FU_NUM][32]  result value.
- fu_rob_idx  in  [FU_NUM][ROB_IDX_W]  ROB entry of the result.
- rd_en  out  [WAYS]  PRF write enable.
- rd_index  out  [WAYS][PRF_IDX_W]  PRF write index.
- rd_data  out  [WAYS][32]  PRF write data.
- complete_valid  out  [WAYS]  ROB completion strobe.
- complete_rob_idx  out  [WAYS][ROB_IDX_W]  completing ROB entry.

Behaviour:
- Reset (sync, active-high): all queues empty, round-robin pointer = 0.
  - rd_en, complete_valid = 0.
  - rd_index, rd_data, complete_rob_idx = 0.
  - fu_ready = all ones from the first cycle after reset.
- Enqueue:
  - fu_ready[i] = (count[i] != QUEUE_DEPTH), from registered count only. No combinational path from fu_valid or from dequeue.
  - A full queue that dequeues this cycle still shows ready = 0.
  - Transfer occurs when fu_valid[i] & fu_ready[i]; the entry (rd_wen, prd, data, rob_idx) is stored at the clock edge.
- Arbitration (combinational on queue heads, each cycle):
  - Scan FUs starting at rr_ptr, wrapping modulo FU_NUM.
  - Grant the first ≤WAYS non-empty queues, at most one entry per FU per cycle.
  - Grant k goes to output way k, in scan order.
- Dequeue and output:
  - Granted heads are popped at the edge.
  - Output registers load: rd_en[k] = head.rd_wen, rd_index, rd_data, complete_valid[k] = 1, complete_rob_idx.
  - Ungranted ways load rd_en = 0 and complete_valid = 0; their index and data fields are don't-care but held at 0.
- Entries with rd_wen = 0 (stores, branches with rd = x0) consume a way: rd_en = 0, complete_valid = 1.
- Latency: an accept in cycle t appears on rd_*/complete_* in cycle t+2 at the earliest. Outputs are valid for exactly one cycle per entry.
- Round-robin pointer:
  - After a cycle with ≥1 grant: rr_ptr = (index of last granted FU + 1) mod FU_NUM.
  - No grants: unchanged.
- Simultaneous enqueue and dequeue on the same queue: both take effect; count is unchanged.
- Ordering: per-FU FIFO order is preserved. No ordering guarantee across FUs.
- Flush:
  - In the flush cycle, inputs are ignored (no enqueue) and no grants are made.
  - All queues are emptied at the edge.
  - Output registers load all-zero enables, so rd_en = 0 and complete_valid = 0 in the cycle after flush.
  - rr_ptr is held.
  - flush and reset asserted together behave as reset.
- Reset mid-operation discards all queued and in-flight results; no PRF write is issued for them.
- Duplicate prd across ways in one cycle is an upstream error. The block passes it through unchanged.

Decomposition:
- defines.svh package holds PRF_INT_WAYS, PRF_INT_INDEX_SIZE, ROB_INDEX_SIZE and a packed struct wb_entry_t {rd_wen, prd, data, rob_idx}.
- Sub-module wb_fifo: synchronous FIFO of wb_entry_t, depth QUEUE_DEPTH.
  - Ports: push, pop, flush, full, empty, head.
  - Instantiated FU_NUM times.
- Arbiter and output registers live in wb_arbiter_int.

Test Plan:
- Single result, WAYS=2: FU1 pushes prd=5, data=0xDEADBEEF, rob=3, rd_wen=1 at cycle 10.
  - Expect rd_en=2'b01, rd_index[0]=5, rd_data[0]=0xDEADBEEF, complete_valid[0]=1, complete_rob_idx[0]=3 in cycle 12 only.
- Oversubscription: all 4 FUs push once in the same cycle, rr_ptr=0.
  - Expect FU0 and FU1 granted on ways 0 and 1 first, then FU2 and FU3 the next cycle; rr_ptr ends at 0.
- Back-pressure: FU0 pushes every cycle while its grants are blocked by higher-priority traffic.
  - Expect fu_ready[0]=0 after 2 accepts; no entry lost or duplicated; data order 1,2,3… preserved on rd_data.
- rd_wen=0 entry with prd=7, rob=9.
  - Expect rd_en=0, complete_valid=1, complete_rob_idx=9.
- Flush with 3 entries buffered: assert flush for 1 cycle.
  - Expect no rd_en/complete_valid afterwards, fu_ready all ones next cycle, and a new push drains normally at +2 latency.
- Reset mid-stream: reset for 1 cycle with queues full.
  - Expect all outputs 0 the next cycle, fu_ready=all ones, rr_ptr=0, and no stale writes.
